// File: rtl/hex_disp_pkg.sv
// Shared types and helpers for the multiplexed hex display scanner.
package hex_disp_pkg;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } state_t;

    // Wide enough for any practical digit count; users slice the low bits.
    localparam logic [63:0] ANODE_OFF = '1;

    // clog2 that never collapses to a zero-width vector.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/phase_counter.sv
// Phase timer for the scanner FSM: counts to the terminal value of the
// current phase, flags it on tc, and restarts from zero as the phase changes.
module phase_counter
    import hex_disp_pkg::*;
#(
    parameter int REFRESH_DIV  = 100000,
    parameter int GUARD_CYCLES = 500
) (
    input  logic   clk,
    input  logic   reset,
    input  state_t state,
    output logic   tc
);

    localparam int CNT_MAX = (REFRESH_DIV > GUARD_CYCLES) ? REFRESH_DIV : GUARD_CYCLES;
    localparam int CNT_W   = idx_width(CNT_MAX);
    localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(GUARD_CYCLES - 1);

    logic [CNT_W-1:0] count;

    always_comb begin
        tc = (count == ((state == ST_SHOW) ? SHOW_LAST : BLANK_LAST));
    end

    // tc is exactly when the FSM changes state, so clearing here restarts each phase at 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (tc) begin
            count <= '0;
        end else begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/hex_display_scanner.sv
// Time-multiplexed driver for a common-anode 7-segment display with guard blanking.
// Optional leading-zero suppression is built when HEX_DISP_LEADING_ZERO_BLANK_EN is defined.
module hex_display_scanner
    import hex_disp_pkg::*;
#(
    parameter int NUM_DIGITS   = 8,
    parameter int REFRESH_DIV  = 100000,
    parameter int GUARD_CYCLES = 500
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [4*NUM_DIGITS-1:0]            data,
    input  logic                               load,
    input  logic [NUM_DIGITS-1:0]              digit_en,
    output logic [3:0]                         Q,
    output logic [NUM_DIGITS-1:0]              anode,
    output logic [idx_width(NUM_DIGITS)-1:0]   digit_idx,
    output logic                               frame_done
);

    localparam int IDX_W  = idx_width(NUM_DIGITS);
    localparam int DATA_W = 4 * NUM_DIGITS;
    localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] ALL_OFF  = ANODE_OFF[NUM_DIGITS-1:0];

    state_t                state, state_next;
    logic                  tc;
    logic [IDX_W-1:0]      idx_next;
    logic [3:0]            q_next;
    logic [NUM_DIGITS-1:0] anode_next;
    logic [NUM_DIGITS-1:0] en_eff;
    logic                  frame_next;
    logic [DATA_W-1:0]     pending, pending_next;
    logic [DATA_W-1:0]     shadow, shadow_next;

    phase_counter #(
        .REFRESH_DIV  (REFRESH_DIV),
        .GUARD_CYCLES (GUARD_CYCLES)
    ) u_phase (
        .clk   (clk),
        .reset (reset),
        .state (state),
        .tc    (tc)
    );

`ifdef HEX_DISP_LEADING_ZERO_BLANK_EN
    logic [NUM_DIGITS-1:0] blank_mask, mask_next;

    // Mask every digit above the most-significant nonzero one; digit 0 always shows.
    function automatic logic [NUM_DIGITS-1:0] lead_zero_mask(input logic [DATA_W-1:0] v);
        logic seen;
        seen = 1'b0;
        lead_zero_mask = '0;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            if (v[4*i +: 4] != 4'h0) begin
                seen = 1'b1;
            end
            lead_zero_mask[i] = !seen;
        end
    endfunction

    always_comb begin
        mask_next = frame_next ? lead_zero_mask(shadow_next) : blank_mask;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            blank_mask <= '0;
        end else begin
            blank_mask <= mask_next;
        end
    end

    assign en_eff = digit_en & ~blank_mask;
`else
    assign en_eff = digit_en;
`endif

    always_comb begin
        state_next   = state;
        idx_next     = digit_idx;
        q_next       = Q;
        anode_next   = ALL_OFF;
        frame_next   = 1'b0;
        pending_next = load ? data : pending;
        shadow_next  = shadow;

        if (state == ST_BLANK) begin
            if (tc) begin
                state_next = ST_SHOW;
                q_next     = shadow[{digit_idx, 2'b00} +: 4];
            end
        end else begin
            if (tc) begin
                state_next = ST_BLANK;
                if (digit_idx == LAST_IDX) begin
                    // Frame boundary: the only point where the displayed word may change.
                    idx_next    = '0;
                    frame_next  = 1'b1;
                    shadow_next = pending_next;
                end else begin
                    idx_next = digit_idx + IDX_W'(1);
                end
            end
        end

        if (state_next == ST_SHOW) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                anode_next[i] = !(en_eff[i] && (digit_idx == IDX_W'(i)));
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_BLANK;
            digit_idx  <= '0;
            Q          <= 4'h0;
            anode      <= ALL_OFF;
            frame_done <= 1'b0;
            pending    <= '0;
            shadow     <= '0;
        end else begin
            state      <= state_next;
            digit_idx  <= idx_next;
            Q          <= q_next;
            anode      <= anode_next;
            frame_done <= frame_next;
            pending    <= pending_next;
            shadow     <= shadow_next;
        end
    end

endmodule

// File: tb/tb_hex_display_scanner.sv
// Directed bench for hex_display_scanner (4 digits, 4-clock SHOW, 2-clock BLANK);
// expectations also cover builds with HEX_DISP_LEADING_ZERO_BLANK_EN defined.
module tb_hex_display_scanner;

    localparam int ND = 4;
    localparam int RD = 4;
    localparam int GC = 2;

`ifdef HEX_DISP_LEADING_ZERO_BLANK_EN
    localparam int         NREC   = 40;
    localparam logic [3:0] POST_Q = 4'h0;
    localparam logic [3:0] Z_AN1  = 4'hF;
    localparam logic [3:0] Z_AN2  = 4'hF;
    localparam logic [3:0] Z_AN3  = 4'hF;
    localparam logic       LD29   = 1'b1;
`else
    localparam int         NREC   = 32;
    localparam logic [3:0] POST_Q = 4'hE;
    localparam logic [3:0] Z_AN1  = 4'hD;
    localparam logic [3:0] Z_AN2  = 4'hB;
    localparam logic [3:0] Z_AN3  = 4'h7;
    localparam logic       LD29   = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] data;
    logic        load;
    logic [3:0]  digit_en;
    logic [3:0]  Q;
    logic [3:0]  anode;
    logic [1:0]  digit_idx;
    logic        frame_done;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    hex_display_scanner #(
        .NUM_DIGITS   (ND),
        .REFRESH_DIV  (RD),
        .GUARD_CYCLES (GC)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .data       (data),
        .load       (load),
        .digit_en   (digit_en),
        .Q          (Q),
        .anode      (anode),
        .digit_idx  (digit_idx),
        .frame_done (frame_done)
    );

    // One record per digit slot: 2 BLANK samples then 4 SHOW samples.
    typedef struct {
        logic        ld;
        logic [15:0] d;
        logic [3:0]  en;
        logic [1:0]  idx;
        logic [3:0]  q;
        logic [3:0]  an;
        logic        fd;
    } slot_t;

    slot_t tbl [NREC];

    function automatic slot_t mk(input logic ld, input logic [15:0] d, input logic [3:0] en,
                                 input logic [1:0] idx, input logic [3:0] q,
                                 input logic [3:0] an, input logic fd);
        slot_t s;
        s.ld = ld; s.d = d; s.en = en; s.idx = idx; s.q = q; s.an = an; s.fd = fd;
        return s;
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_slot(input slot_t s, input int n, input bit skip);
        if (s.ld) data = s.d;
        load     = s.ld;
        digit_en = s.en;
        for (int c = (skip ? 1 : 0); c < 6; c++) begin
            @(posedge clk);
            @(negedge clk);
            load = 1'b0;
            check($sformatf("slot%0d.c%0d anode", n, c), 16'(anode), 16'((c < 2) ? 4'hF : s.an));
            check($sformatf("slot%0d.c%0d digit_idx", n, c), 16'(digit_idx), 16'(s.idx));
            check($sformatf("slot%0d.c%0d frame_done", n, c), 16'(frame_done),
                  16'((c == 0) ? s.fd : 1'b0));
            if (c >= 2) begin
                check($sformatf("slot%0d.c%0d Q", n, c), 16'(Q), 16'(s.q));
            end
        end
    endtask

    initial begin
        // Frame 0 shows reset shadow (0); 1A2F appears from frame 1.
        tbl[0]  = mk(1'b1, 16'h1A2F, 4'hF, 2'd0, 4'h0, 4'hE, 1'b0);
        tbl[1]  = mk(1'b0, 16'h0000, 4'hF, 2'd1, 4'h0, 4'hD, 1'b0);
        tbl[2]  = mk(1'b0, 16'h0000, 4'hF, 2'd2, 4'h0, 4'hB, 1'b0);
        tbl[3]  = mk(1'b0, 16'h0000, 4'hF, 2'd3, 4'h0, 4'h7, 1'b0);
        tbl[4]  = mk(1'b0, 16'h0000, 4'hF, 2'd0, 4'hF, 4'hE, 1'b1);
        tbl[5]  = mk(1'b0, 16'h0000, 4'hF, 2'd1, 4'h2, 4'hD, 1'b0);
        tbl[6]  = mk(1'b0, 16'h0000, 4'hF, 2'd2, 4'hA, 4'hB, 1'b0);
        tbl[7]  = mk(1'b0, 16'h0000, 4'hF, 2'd3, 4'h1, 4'h7, 1'b0);
        tbl[8]  = mk(1'b0, 16'h0000, 4'hF, 2'd0, 4'hF, 4'hE, 1'b1);
        tbl[9]  = mk(1'b0, 16'h0000, 4'hF, 2'd1, 4'h2, 4'hD, 1'b0);
        tbl[10] = mk(1'b1, 16'h1234, 4'hF, 2'd2, 4'hA, 4'hB, 1'b0);
        tbl[11] = mk(1'b0, 16'h0000, 4'hF, 2'd3, 4'h1, 4'h7, 1'b0);
        // digit_en = 0101: digits 1 and 3 dark while Q keeps stepping.
        tbl[12] = mk(1'b0, 16'h0000, 4'h5, 2'd0, 4'h4, 4'hE, 1'b1);
        tbl[13] = mk(1'b0, 16'h0000, 4'h5, 2'd1, 4'h3, 4'hF, 1'b0);
        tbl[14] = mk(1'b1, 16'h0000, 4'h5, 2'd2, 4'h2, 4'hB, 1'b0);
        tbl[15] = mk(1'b0, 16'h0000, 4'h5, 2'd3, 4'h1, 4'hF, 1'b0);
        // 0000 displayed; BEEF loaded mid-frame must wait for the next frame.
        tbl[16] = mk(1'b0, 16'h0000, 4'hF, 2'd0, 4'h0, 4'hE, 1'b1);
        tbl[17] = mk(1'b1, 16'hBEEF, 4'hF, 2'd1, 4'h0, Z_AN1, 1'b0);
        tbl[18] = mk(1'b0, 16'h0000, 4'hF, 2'd2, 4'h0, Z_AN2, 1'b0);
        tbl[19] = mk(1'b0, 16'h0000, 4'hF, 2'd3, 4'h0, Z_AN3, 1'b0);
        tbl[20] = mk(1'b0, 16'h0000, 4'hF, 2'd0, 4'hF, 4'hE, 1'b1);
        tbl[21] = mk(1'b1, 16'h9999, 4'hF, 2'd1, 4'hE, 4'hD, 1'b0);
        tbl[22] = mk(1'b0, 16'h0000, 4'hF, 2'd2, 4'hE, 4'hB, 1'b0);
        tbl[23] = mk(1'b0, 16'h0000, 4'hF, 2'd3, 4'hB, 4'h7, 1'b0);
        // Load on the wrap edge reaches shadow at once, overriding pending 9999.
        tbl[24] = mk(1'b1, 16'h5555, 4'hF, 2'd0, 4'h5, 4'hE, 1'b1);
        tbl[25] = mk(1'b1, 16'h3333, 4'hF, 2'd1, 4'h5, 4'hD, 1'b0);
        tbl[26] = mk(1'b1, 16'hC0DE, 4'hF, 2'd2, 4'h5, 4'hB, 1'b0);
        tbl[27] = mk(1'b0, 16'h0000, 4'hF, 2'd3, 4'h5, 4'h7, 1'b0);
        tbl[28] = mk(1'b0, 16'h0000, 4'hF, 2'd0, 4'hE, 4'hE, 1'b1);
        tbl[29] = mk(LD29, 16'h0042, 4'hF, 2'd1, 4'hD, 4'hD, 1'b0);
        tbl[30] = mk(1'b0, 16'h0000, 4'hF, 2'd2, 4'h0, 4'hB, 1'b0);
        tbl[31] = mk(1'b0, 16'h0000, 4'hF, 2'd3, 4'hC, 4'h7, 1'b0);
`ifdef HEX_DISP_LEADING_ZERO_BLANK_EN
        tbl[32] = mk(1'b0, 16'h0000, 4'hF, 2'd0, 4'h2, 4'hE, 1'b1);
        tbl[33] = mk(1'b1, 16'h0000, 4'hF, 2'd1, 4'h4, 4'hD, 1'b0);
        tbl[34] = mk(1'b0, 16'h0000, 4'hF, 2'd2, 4'h0, 4'hF, 1'b0);
        tbl[35] = mk(1'b0, 16'h0000, 4'hF, 2'd3, 4'h0, 4'hF, 1'b0);
        tbl[36] = mk(1'b0, 16'h0000, 4'hF, 2'd0, 4'h0, 4'hE, 1'b1);
        tbl[37] = mk(1'b0, 16'h0000, 4'hF, 2'd1, 4'h0, 4'hF, 1'b0);
        tbl[38] = mk(1'b0, 16'h0000, 4'hF, 2'd2, 4'h0, 4'hF, 1'b0);
        tbl[39] = mk(1'b0, 16'h0000, 4'hF, 2'd3, 4'h0, 4'hF, 1'b0);
`endif

        reset    = 1'b1;
        load     = 1'b0;
        data     = 16'h0000;
        digit_en = 4'hF;
        repeat (2) @(negedge clk);
        check("reset anode", 16'(anode), 16'hF);
        check("reset Q", 16'(Q), 16'h0);
        check("reset digit_idx", 16'(digit_idx), 16'h0);
        check("reset frame_done", 16'(frame_done), 16'h0);
        reset = 1'b0;

        for (int n = 0; n < NREC; n++) begin
            run_slot(tbl[n], n, (n == 0));
        end

        // Wrap edge, two BLANK clocks, then first SHOW clock of digit 0.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("post-table anode", 16'(anode), 16'hE);
        check("post-table Q", 16'(Q), 16'(POST_Q));

        digit_en = 4'hE;
        @(posedge clk);
        #1;
        check("en clear mid-SHOW anode", 16'(anode), 16'hF);
        digit_en = 4'hF;

        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("async reset anode", 16'(anode), 16'hF);
        check("async reset Q", 16'(Q), 16'h0);
        check("async reset digit_idx", 16'(digit_idx), 16'h0);
        check("async reset frame_done", 16'(frame_done), 16'h0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        run_slot(mk(1'b0, 16'h0000, 4'hF, 2'd0, 4'h0, 4'hE, 1'b0), 100, 1'b1);
        run_slot(mk(1'b0, 16'h0000, 4'hF, 2'd1, 4'h0, 4'hD, 1'b0), 101, 1'b0);
        run_slot(mk(1'b0, 16'h0000, 4'hF, 2'd2, 4'h0, 4'hB, 1'b0), 102, 1'b0);
        run_slot(mk(1'b0, 16'h0000, 4'hF, 2'd3, 4'h0, 4'h7, 1'b0), 103, 1'b0);
        run_slot(mk(1'b0, 16'h0000, 4'hF, 2'd0, 4'h0, 4'hE, 1'b1), 104, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
